// File: rtl/dsi_pkg.sv
// Shared types and default sizing for the DSI clock monitor and related lane monitors.
package dsi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SEARCH = 2'd2,
        LOCKED = 2'd3
    } mon_state_e;

    localparam int DSI_CNT_W_DEF       = 16;
    localparam int DSI_LOCK_CNT_DEF    = 4;
    localparam int DSI_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/dsi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous clock/strobe plus a history flop
// giving single-cycle rise and fall strobes in the sampling domain.
module dsi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;
    assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/dsi_clk_monitor.sv
// Measures period/high time of dsi_clk_in in pclk cycles, tracks lock against an
// expected period with tolerance, and flags range and stuck-clock errors.
module dsi_clk_monitor
    import dsi_pkg::*;
#(
    parameter int CNT_W       = DSI_CNT_W_DEF,
    parameter int SYNC_STAGES = DSI_SYNC_STAGES_DEF,
    parameter int LOCK_CNT    = DSI_LOCK_CNT_DEF
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             enable,
    input  logic             dsi_clk_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [7:0]       tol,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid,
    output logic             locked,
    output logic             lock_lost,
    output logic             err_range,
    output logic             err_stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam int               CMP_W    = (CNT_W + 1 > 8) ? CNT_W + 1 : 8;

    // |meas - expv| <= t, evaluated one bit wider than the counters so nothing wraps.
    function automatic logic in_tol(input logic [CNT_W-1:0] meas,
                                    input logic [CNT_W-1:0] expv,
                                    input logic [7:0]       t);
        logic signed [CNT_W:0] diff;
        logic        [CNT_W:0] mag;
        logic        [CMP_W-1:0] mag_w;
        logic        [CMP_W-1:0] tol_w;
        diff  = $signed({1'b0, meas}) - $signed({1'b0, expv});
        mag   = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        mag_w = CMP_W'(mag);
        tol_w = CMP_W'(t);
        return (mag_w <= tol_w);
    endfunction

    logic clk_sync;
    logic clk_rise;
    logic clk_fall_unused;

    dsi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .async_i(dsi_clk_in),
        .sync_o (clk_sync),
        .rise_o (clk_rise),
        .fall_o (clk_fall_unused)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             lock_lost_q, lock_lost_d;
    logic             err_range_q, err_range_d;
    logic             err_stuck_q, err_stuck_d;

    logic             good_period;
    logic [3:0]       good_inc;

    assign good_period = in_tol(p_cnt_q, exp_period, tol);
    assign good_inc    = good_cnt_q + 4'd1;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            p_cnt_q      <= '0;
            h_cnt_q      <= '0;
            good_cnt_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            err_range_q  <= 1'b0;
            err_stuck_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_cnt_q      <= p_cnt_d;
            h_cnt_q      <= h_cnt_d;
            good_cnt_q   <= good_cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            err_range_q  <= err_range_d;
            err_stuck_q  <= err_stuck_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p_cnt_d      = p_cnt_q;
        h_cnt_d      = h_cnt_q;
        good_cnt_d   = good_cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        lock_lost_d  = 1'b0;
        err_range_d  = err_range_q;
        err_stuck_d  = err_stuck_q;

        if (!enable || (state_q == IDLE)) begin
            // Disable wins over any rise or saturation in the same cycle.
            state_d     = enable ? ARM : IDLE;
            p_cnt_d     = '0;
            h_cnt_d     = '0;
            good_cnt_d  = '0;
            err_range_d = 1'b0;
            err_stuck_d = 1'b0;
        end else if (p_cnt_q == CNT_MAX) begin
            state_d     = ARM;
            p_cnt_d     = '0;
            h_cnt_d     = '0;
            good_cnt_d  = '0;
            err_stuck_d = 1'b1;
            lock_lost_d = (state_q == LOCKED);
        end else begin
            if (clk_rise) begin
                p_cnt_d = CNT_ONE;
                h_cnt_d = CNT_ONE;
            end else begin
                p_cnt_d = p_cnt_q + 1'b1;
                if (clk_sync && (h_cnt_q != CNT_MAX)) begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end

            if (clk_rise) begin
                case (state_q)
                    ARM: begin
                        state_d    = SEARCH;
                        good_cnt_d = '0;
                    end
                    SEARCH, LOCKED: begin
                        // Capture takes the counts before the reload above.
                        period_d     = p_cnt_q;
                        high_d       = h_cnt_q;
                        meas_valid_d = 1'b1;
                        if (good_period) begin
                            if ((state_q == SEARCH) && (good_inc >= LOCK_TGT)) begin
                                state_d = LOCKED;
                            end
                            if (state_q == SEARCH) begin
                                good_cnt_d = good_inc;
                            end
                        end else begin
                            err_range_d = 1'b1;
                            good_cnt_d  = '0;
                            lock_lost_d = (state_q == LOCKED);
                            state_d     = SEARCH;
                        end
                    end
                    default: ;
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
    end

    assign period_o   = period_q;
    assign high_o     = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;
    assign err_range  = err_range_q;
    assign err_stuck  = err_stuck_q;

endmodule

// File: doc/dsi_clk_monitor.md
Name: dsi_clk_monitor

Overview:
- Checks the DSI byte/bit clock produced by the DSI clock generator. It runs entirely in the pclk domain.
- Measures the period and high time of the incoming dsi_clk in pclk cycles and compares the period against a programmed expectation with tolerance.
- Reports lock status, range errors and a stuck-clock error to the DSI register block (status register / interrupt sources).
- Requires dsi_clk frequency ≤ pclk/4 for valid measurements. It is used with the /DIV test configurations and slowed-clock modes.

Parameters:
- CNT_W, 16, width of the period/high-time counters and of exp_period.
- SYNC_STAGES, 2, synchronizer depth for dsi_clk_in (minimum 2).
- LOCK_CNT, 4, consecutive in-tolerance periods required to declare lock (1..15).

Ports:
- pclk  in  1  system clock; all logic on its rising edge.
- presetn  in  1  asynchronous active-low reset.
- enable  in  1  monitor enable (from dsi_ctrl register).
- dsi_clk_in  in  1  clock under test, asynchronous to pclk.
- exp_period  in  CNT_W  expected period in pclk cycles.
- tol  in  8  allowed absolute deviation in pclk cycles.
- period_o  out  CNT_W  last measured period.
- high_o  out  CNT_W  last measured high time.
- meas_valid  out  1  one-cycle pulse when period_o/high_o update.
- locked  out  1  lock status.
- lock_lost  out  1  one-cycle pulse on LOCKED→SEARCH.
- err_range  out  1  sticky: any out-of-tolerance period while enabled.
- err_stuck  out  1  sticky: counter saturated with no rising edge.

Behaviour:
- Reset: presetn=0 asynchronously clears every flop, including the synchronizer. All outputs are 0. FSM enters IDLE.
- Sampling: dsi_clk_in passes through SYNC_STAGES flops, then one history flop.
- Edge detection: rise = sync & ~hist; fall = ~sync & hist. Detection lags the true edge by SYNC_STAGES+1 cycles.
- Period counter p_cnt: loads 1 in a rise cycle; otherwise increments, saturating at 2^CNT_W−1.
- High counter h_cnt: loads 1 on rise; increments while sync=1; holds while sync=0.
- Capture: on a rise in any state other than IDLE/ARM, period_o ← p_cnt and high_o ← h_cnt (pre-reload values). meas_valid pulses in the same cycle the outputs change.
- Good check: a period is good iff |period − exp_period| ≤ tol.
  - Compute the difference at CNT_W+1 bits signed; no wrap.
  - exp_period and tol are sampled in the capture cycle.
- FSM:
  - IDLE: enable=0. Counters are held at 0; good_cnt=0; locked=0. Sticky errors are cleared while in IDLE. enable=1 → ARM.
  - ARM: the first rise only starts counting; no capture → SEARCH.
  - SEARCH: each capture with a good period increments good_cnt; a bad period sets good_cnt=0 and sets err_range. good_cnt reaching LOCK_CNT → LOCKED, with locked=1 from the next cycle.
  - LOCKED: a good period stays in LOCKED. A bad period sets err_range, pulses lock_lost, sets good_cnt=0 → SEARCH, and locked=0 from the next cycle.
  - Any non-IDLE state: p_cnt saturating (reaching 2^CNT_W−1) sets err_stuck, sets locked=0 and → ARM. If the state was LOCKED, lock_lost also pulses.
  - Any state: enable=0 → IDLE next cycle. This overrides a simultaneous rise or saturation; no capture occurs that cycle.
- A change to exp_period while LOCKED only takes effect at the next capture. There is no forced relock.
- Sticky errors clear only via IDLE or reset.

Decomposition:
- Package dsi_pkg:
  - mon_state_e enum: IDLE, ARM, SEARCH, LOCKED.
  - Default constants for CNT_W and LOCK_CNT.
- Sub-module dsi_sync_edge: synchronizer plus rise/fall detector, parameterized by SYNC_STAGES. It is reusable by other DSI lane monitors.

Test Plan:
- dsi_clk period 12 pclk (6 high), exp_period=12, tol=1, enable=1 → locked rises after the 5th rising edge (1 arm + 4 good); period_o=12, high_o=6; err flags 0.
- Tolerance boundary: periods 13 then 11 with exp 12, tol 1 → both good, lock retained. Period 14 → err_range=1, lock_lost pulses once, locked=0.
- Frequency step: locked at 12, switch dsi_clk to 16 and set exp_period=16 → one lock_lost. Relock after 4 periods of 16; err_range stays 1 until enable toggles.
- Stuck clock: CNT_W=8, hold dsi_clk_in low after lock → err_stuck=1 and locked=0 once p_cnt reaches 255; the state returns to ARM. Restoring the clock relocks; err_stuck stays 1.
- Enable/edge collision: deassert enable in the same cycle a rise is detected → no meas_valid, IDLE next cycle, all errors cleared, locked=0.
- Reset mid-lock: pulse presetn low asynchronously (between pclk edges) while LOCKED → outputs 0 immediately. After release with enable=1, lock takes 1 arm + 4 periods again.
